// File: rtl/uart_sram_loader.sv
// UART byte-to-SRAM loader: packs received bytes little-endian into 32-bit
// words and writes them to SRAM from BASE_ADDR over a req/ack handshake.
// Ports: clk, rst (sync, active-high); start/flush pulses; rx_valid/rx_data
// byte strobe; sram_req/addr/wdata/be out, sram_ack in; busy, done, overrun,
// word_count status. Optional LOADER_CHECKSUM_EN adds checksum[7:0], the
// mod-256 sum of all bytes in accepted words.
module uart_sram_loader #(
  parameter int              ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_be,
  input  logic              sram_ack,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W-1:0] word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int          CW   = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [1:0]        lane_q;
  logic [31:0]       buf_q;
  logic              pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              held_q;
  logic [31:0]       hdata_q;
  logic [3:0]        hbe_q;
  logic [ADDR_W-1:0] wc_q;
  logic              ovr_q;
  logic [CW-1:0]     acc_q;

  logic        in_collect;
  logic        take;
  logic        full;
  logic        part;
  logic        flush_now;
  logic        ack_now;
  logic        slot_free;
  logic        at_limit;
  logic [1:0]  lane_n;
  logic [31:0] buf_n;
  logic [3:0]  part_be;
  logic [31:0] part_data;
  logic [31:0] new_word;
  logic [3:0]  new_be;

  assign in_collect = (state_q == S_COLLECT);
  assign take       = rx_valid && in_collect;
  assign full       = take && (lane_q == 2'd3);
  assign lane_n     = take ? lane_q + 2'd1 : lane_q;
  assign flush_now  = flush && in_collect;
  // A byte arriving with flush is packed first, so the partial uses lane_n.
  assign part       = flush_now && (lane_n != 2'd0);
  assign ack_now    = pend_q && sram_ack;
  assign slot_free  = !pend_q || sram_ack;
  assign at_limit   = (32'(acc_q) + 32'd1) == MAXW;

  always_comb begin
    buf_n   = buf_q;
    part_be = 4'b0000;
    if (take) begin
      buf_n[{lane_q, 3'b000} +: 8] = rx_data;
    end
    unique case (lane_n)
      2'd1:    part_be = 4'b0001;
      2'd2:    part_be = 4'b0011;
      2'd3:    part_be = 4'b0111;
      default: part_be = 4'b0000;
    endcase
  end

  // Stale bytes from an earlier word sit in the unused lanes; zero them.
  assign part_data = buf_n & {{8{part_be[3]}}, {8{part_be[2]}},
                              {8{part_be[1]}}, {8{part_be[0]}}};
  assign new_word  = full ? buf_n : part_data;
  assign new_be    = full ? 4'b1111 : part_be;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] word_sum;
  assign word_sum = new_word[7:0] + new_word[15:8]
                  + new_word[23:16] + new_word[31:24];
  assign checksum = csum_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      buf_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      held_q  <= 1'b0;
      hdata_q <= '0;
      hbe_q   <= '0;
      wc_q    <= '0;
      ovr_q   <= 1'b0;
      acc_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_COLLECT;
            addr_q  <= BASE_ADDR;
            lane_q  <= '0;
            wc_q    <= '0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
            held_q  <= 1'b0;
            acc_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        S_COLLECT: begin
          lane_q <= lane_n;
          buf_q  <= buf_n;
          if (ack_now) begin
            pend_q <= 1'b0;
            addr_q <= addr_q + ADDR_W'(1);
            wc_q   <= wc_q + ADDR_W'(1);
          end
          if (full || part) begin
            if (slot_free) begin
              wdata_q <= new_word;
              be_q    <= new_be;
              pend_q  <= 1'b1;
            end else if (part) begin
              // Final partial waits behind the busy slot; never dropped.
              held_q  <= 1'b1;
              hdata_q <= new_word;
              hbe_q   <= new_be;
            end else begin
              ovr_q   <= 1'b1;
            end
            if (slot_free || part) begin
              acc_q <= acc_q + CW'(1);
`ifdef LOADER_CHECKSUM_EN
              csum_q <= csum_q + word_sum;
`endif
              if (at_limit) begin
                state_q <= S_DRAIN;
              end
            end
          end
          if (flush_now) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ack_now) begin
            pend_q <= 1'b0;
            addr_q <= addr_q + ADDR_W'(1);
            wc_q   <= wc_q + ADDR_W'(1);
            if (held_q) begin
              wdata_q <= hdata_q;
              be_q    <= hbe_q;
              pend_q  <= 1'b1;
              held_q  <= 1'b0;
            end
          end
          if (!pend_q && !held_q) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sram_req   = pend_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_be    = be_q;
  assign busy       = in_collect || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign overrun    = ovr_q;
  assign word_count = wc_q;

endmodule
